// File: rtl/nr_div_stream.sv
// Block-serial unsigned non-restoring divider: loads dividend/divisor as BLOCK-bit beats,
// resolves UNROLL quotient bits per cycle, then streams quotient and remainder out.
module nr_div_stream #(
  parameter int N      = 4096,
  parameter int M      = 2048,
  parameter int BLOCK  = 128,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLOCK-1:0] in_dvd,
  input  logic [BLOCK-1:0] in_dvs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLOCK-1:0] out_data,
  output logic             out_sel,
  output logic             out_last,
  output logic             out_dz
);

  localparam int NB    = N / BLOCK;
  localparam int MB    = M / BLOCK;
  localparam int NSTEP = N / UNROLL;
  localparam int CW    = $clog2(N + M + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, CORR, OUT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    dq_r;     // dividend while loading/calculating, quotient afterwards
  logic [M-1:0]    dvs_r;
  logic [M:0]      p_r;      // signed partial remainder; low M bits become the remainder
  logic [M:0]      p_step;
  logic [UNROLL-1:0] q_step;
  logic            dz_r;
  logic            in_fire, out_fire;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // the producer holds valid and payload until that edge, ready never depends on valid.
  assign in_ready  = (state == IDLE || state == LOAD) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == OUT);
  assign out_fire  = out_valid && out_ready;
  assign out_sel   = out_valid && (cnt >= CW'(NB));
  assign out_last  = out_valid && (cnt == CW'(NB + MB - 1));
  assign out_dz    = out_valid && dz_r;

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = out_sel ? p_r[M-1 -: BLOCK] : dq_r[N-1 -: BLOCK];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, LOAD: if (in_fire) state_nxt = (cnt == CW'(NB - 1)) ? CALC : LOAD;
      CALC:       if (cnt == CW'(NSTEP - 1)) state_nxt = CORR;
      CORR:       state_nxt = OUT;
      OUT:        if (out_fire && out_last) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // UNROLL non-restoring steps chained in one cycle; the add/subtract choice follows
  // the sign of P before the shift, intermediate wrap in M+1 bits is harmless.
  always_comb begin
    logic [M:0] p_tmp;
    logic       sub;
    p_tmp  = p_r;
    q_step = '0;
    for (int i = 0; i < UNROLL; i++) begin
      sub   = ~p_tmp[M];
      p_tmp = {p_tmp[M-1:0], dq_r[N-1-i]};
      p_tmp = sub ? (p_tmp - {1'b0, dvs_r}) : (p_tmp + {1'b0, dvs_r});
      q_step[UNROLL-1-i] = ~p_tmp[M];
    end
    p_step = p_tmp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dq_r  <= '0;
      dvs_r <= '0;
      p_r   <= '0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          p_r <= '0;
          if (in_fire) begin
            dq_r <= (dq_r << BLOCK) | N'(in_dvd);
            if (cnt < CW'(MB)) dvs_r <= (dvs_r << BLOCK) | M'(in_dvs);
            cnt <= (cnt == CW'(NB - 1)) ? '0 : cnt + CW'(1);
          end
        end
        CALC: begin
          p_r  <= p_step;
          dq_r <= (dq_r << UNROLL) | N'(q_step);
          cnt  <= (cnt == CW'(NSTEP - 1)) ? '0 : cnt + CW'(1);
        end
        CORR: begin
          // With a zero divisor P has simply accumulated the dividend, so its
          // low M bits already equal dvd[M-1:0]; only the quotient is forced.
          if (p_r[M]) p_r <= p_r + {1'b0, dvs_r};
          dz_r <= (dvs_r == '0);
          if (dvs_r == '0) dq_r <= '1;
        end
        OUT: begin
          if (out_fire) begin
            if (out_sel) p_r  <= p_r << BLOCK;
            else         dq_r <= dq_r << BLOCK;
            cnt <= out_last ? '0 : cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_div_stream.sv
// Directed bench for nr_div_stream at N=16, M=8, BLOCK=8; UNROLL=2 and UNROLL=4 copies
// share the input stream and are checked for results and latency.
module tb_nr_div_stream;

  localparam int N = 16, M = 8, BLOCK = 8, NB = 2, MB = 1, W = BLOCK + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid, in_ready, in_ready2, in_ready4;
  logic [BLOCK-1:0] in_dvd, in_dvs;
  logic             out_valid, out_ready, out_sel, out_last, out_dz;
  logic [BLOCK-1:0] out_data, out_data2, out_data4;
  logic             out_valid2, out_sel2, out_last2, out_dz2;
  logic             out_valid4, out_sel4, out_last4, out_dz4;
  logic             aux_ready = 1'b1;

  nr_div_stream #(.N(N), .M(M), .BLOCK(BLOCK), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dvd(in_dvd), .in_dvs(in_dvs), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last), .out_dz(out_dz));

  nr_div_stream #(.N(N), .M(M), .BLOCK(BLOCK), .UNROLL(2)) dut_u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_dvd(in_dvd), .in_dvs(in_dvs), .out_valid(out_valid2), .out_ready(aux_ready),
    .out_data(out_data2), .out_sel(out_sel2), .out_last(out_last2), .out_dz(out_dz2));

  nr_div_stream #(.N(N), .M(M), .BLOCK(BLOCK), .UNROLL(4)) dut_u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_dvd(in_dvd), .in_dvs(in_dvs), .out_valid(out_valid4), .out_ready(aux_ready),
    .out_data(out_data4), .out_sel(out_sel4), .out_last(out_last4), .out_dz(out_dz4));

  // Scoreboard entries are {dz, sel, last, data}.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_save[$];
  logic [W-1:0] got2[$];
  logic [W-1:0] got4[$];
  int first2, first4, load_cyc;
  logic ov2_d = 1'b0, ov4_d = 1'b0;
  int n_tests = 0, n_fail = 0;

  // The unrolled copies always accept, so every valid cycle is one output beat.
  always @(negedge clk) begin
    if (rst) begin
      ov2_d = 1'b0;
      ov4_d = 1'b0;
    end else begin
      if (out_valid2 && !ov2_d) first2 = cyc;
      if (out_valid4 && !ov4_d) first4 = cyc;
      ov2_d = out_valid2;
      ov4_d = out_valid4;
      if (out_valid2) got2.push_back({out_dz2, out_sel2, out_last2, out_data2});
      if (out_valid4) got4.push_back({out_dz4, out_sel4, out_last4, out_data4});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] dvd, input logic [7:0] dvs, input bit gaps);
    for (int b = 0; b < NB; b++) begin
      int n;
      if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
      in_valid = 1'b1;
      in_dvd   = dvd[15-8*b -: 8];
      in_dvs   = (b < MB) ? dvs : 8'($urandom_range(0, 255));
      n = 0;
      while (!in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("load_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      load_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  task automatic collect(input string tag, input bit stall, input bit thr, input int lat);
    int n = 0, got = 0, first = -1, hold_left = 0;
    logic [W-1:0] hold, obs, e;
    while (got < NB + MB && n < 400) begin
      @(negedge clk);
      n++;
      obs = {out_dz, out_sel, out_last, out_data};
      if (out_valid && first < 0) begin
        first = cyc;
        hold  = obs;
        if (stall) begin
          out_ready = 1'b0;
          hold_left = 10;
          continue;
        end
      end
      if (hold_left > 0) begin
        check({tag, "_stall"}, {20'd0, out_valid, obs}, {20'd0, 1'b1, hold});
        hold_left--;
        if (hold_left > 0) continue;
      end
      out_ready = (thr && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check({tag, "_beat"}, 32'(obs), 32'(e));
        got++;
      end
    end
    check({tag, "_beats"}, got, NB + MB);
    check({tag, "_latency"}, first - load_cyc, lat);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  task automatic check_aux(input string tag);
    check({tag, "_u2_count"}, got2.size(), NB + MB);
    check({tag, "_u4_count"}, got4.size(), NB + MB);
    for (int i = 0; i < NB + MB; i++) begin
      if (i < got2.size()) check({tag, "_u2_beat"}, 32'(got2[i]), 32'(exp_save[i]));
      if (i < got4.size()) check({tag, "_u4_beat"}, 32'(got4[i]), 32'(exp_save[i]));
    end
    check({tag, "_u2_latency"}, first2 - load_cyc, N / 2 + 1);
    check({tag, "_u4_latency"}, first4 - load_cyc, N / 4 + 1);
  endtask

  task automatic run(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                     input logic [15:0] q, input logic [7:0] r, input bit dz,
                     input bit gaps, input bit stall, input bit thr);
    exp_q.delete();
    exp_save.delete();
    got2.delete();
    got4.delete();
    first2 = -1000;
    first4 = -1000;
    exp_save.push_back({dz, 1'b0, 1'b0, q[15:8]});
    exp_save.push_back({dz, 1'b0, 1'b0, q[7:0]});
    exp_save.push_back({dz, 1'b1, 1'b1, r});
    foreach (exp_save[i]) exp_q.push_back(exp_save[i]);
    load(dvd, dvs, gaps);
    collect(tag, stall, thr, N + 1);
    check_aux(tag);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_dvd = '0;
    in_dvs = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_flags", {29'd0, out_sel, out_last, out_dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {29'd0, in_ready, in_ready2, in_ready4}, 32'd7);

    //       tag       dvd       dvs    q         r      dz gap stl thr
    run("t1",       16'h1234, 8'h07, 16'h0299, 8'h05, 0, 0, 0, 0);
    run("t2_dz",    16'h00FF, 8'h00, 16'hFFFF, 8'hFF, 1, 0, 0, 0);
    run("t3_small", 16'h0005, 8'h09, 16'h0000, 8'h05, 0, 0, 0, 0);
    run("t3_max",   16'hFFFF, 8'hFF, 16'h0101, 8'h00, 0, 0, 0, 0);
    run("t4_stall", 16'h1234, 8'h07, 16'h0299, 8'h05, 0, 1, 1, 0);
    run("v_abcd",   16'hABCD, 8'hFF, 16'h00AC, 8'h79, 0, 1, 0, 1);
    run("v_7fff",   16'h7FFF, 8'hFE, 16'h0081, 8'h01, 0, 0, 0, 1);
    run("v_8000",   16'h8000, 8'h80, 16'h0100, 8'h00, 0, 1, 0, 1);
    run("v_div1",   16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 0, 0, 0, 0);
    run("v_dz2",    16'hABCD, 8'h00, 16'hFFFF, 8'hCD, 1, 1, 0, 1);

    // Abort a division mid-calculation, then check the next one starts clean.
    load(16'hBEEF, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    check("t5_rst_out", {20'd0, out_valid, out_sel, out_last, out_dz, out_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", {30'd0, in_ready, out_valid}, 32'd2);
    run("t5_after", 16'h1234, 8'h07, 16'h0299, 8'h05, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
